led_pwm_ctrl: RTL and testbench



---
 rtl/led_pkg.sv | 16 +
 rtl/led_pwm_ctrl_pwm_timebase.sv | 36 +++
 rtl/led_pwm_ctrl.sv | 126 ++++++++++++
 tb/tb_led_pwm_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED PWM controller: register map, FSM states, defaults.
package led_pkg;
  localparam int LED_N            = 8;
  localparam int LED_DEF_PRESCALE = 16;
  localparam int LED_DEF_DUTY_W   = 4;

  localparam logic [3:0] LED_DUTY0  = 4'd0;
  localparam logic [3:0] LED_EN     = 4'd8;
  localparam logic [3:0] LED_STATUS = 4'd9;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FROZEN = 2'd2
  } led_state_e;
endpackage

// File: rtl/led_pwm_ctrl_pwm_timebase.sv
// Prescaler plus PWM period counter; run gates both, clear forces both to zero.
module pwm_timebase #(
  parameter int PRESCALE = 16,
  parameter int DUTY_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear,
  output logic              tick,
  output logic              period_end,
  output logic [DUTY_W-1:0] pwm_cnt
);
  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CNT_MAX  = '1;

  logic [PRE_W-1:0] pre_cnt;

  assign tick       = run && (pre_cnt == PRE_LAST);
  assign period_end = tick && (pwm_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (run) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      // pwm_cnt wraps naturally from all-ones to zero
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_pwm_ctrl.sv
// LED controller: shadow/active duty registers committed at period start,
// PWM drive, and a sleep FSM that freezes the pads only at a clean period end.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int PRESCALE = LED_DEF_PRESCALE,
  parameter int DUTY_W   = LED_DEF_DUTY_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rd_data,
  input  logic       core_wfi,
  output logic [7:0] led_bus,
  output logic       wfi
);
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  led_state_e state;

  logic [LED_N-1:0][DUTY_W-1:0] duty_shadow, duty_act;
  logic [LED_N-1:0]             en_shadow, en_act;
  logic                         pending;

  logic              tick, period_end, run, clear, wake, commit, wr_ok;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [LED_N-1:0]  led_nxt;

  assign run    = (state != ST_FROZEN);
  assign clear  = (state == ST_DRAIN) && core_wfi && period_end;
  assign wake   = (state == ST_FROZEN) && !core_wfi;
  assign commit = period_end || wake;
  assign wr_ok  = wr_en && (addr <= LED_EN);

  pwm_timebase #(.PRESCALE(PRESCALE), .DUTY_W(DUTY_W)) u_tb (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .clear      (clear),
    .tick       (tick),
    .period_end (period_end),
    .pwm_cnt    (pwm_cnt)
  );

  // All-ones duty is forced on so full brightness never shows a dark slot.
  for (genvar i = 0; i < LED_N; i++) begin : g_led
    assign led_nxt[i] = en_act[i] &&
                        ((pwm_cnt < duty_act[i]) || (duty_act[i] == DUTY_MAX));
  end

  // A write in the commit cycle lands in shadow after the commit copied the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
      duty_act    <= '0;
      en_shadow   <= '0;
      en_act      <= '0;
      pending     <= 1'b0;
    end else begin
      if (commit) begin
        duty_act <= duty_shadow;
        en_act   <= en_shadow;
      end
      if (wr_ok) begin
        if (addr == LED_EN) en_shadow <= wdata;
        else                duty_shadow[addr[2:0]] <= wdata[DUTY_W-1:0];
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (addr < LED_EN)          rd_data <= 8'(duty_shadow[addr[2:0]]);
      else if (addr == LED_EN)     rd_data <= en_shadow;
      else if (addr == LED_STATUS) rd_data <= {6'b0, pending, state == ST_FROZEN};
      else                         rd_data <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      wfi     <= 1'b0;
      led_bus <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          led_bus <= led_nxt;
          if (core_wfi) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!core_wfi) begin
            state   <= ST_RUN;
            led_bus <= led_nxt;
          end else if (period_end) begin
            state   <= ST_FROZEN;
            wfi     <= 1'b1;
            led_bus <= '0;
          end else begin
            led_bus <= led_nxt;
          end
        end
        ST_FROZEN: begin
          led_bus <= '0;
          if (!core_wfi) begin
            state <= ST_RUN;
            wfi   <= 1'b0;
          end
        end
        default: begin
          state   <= ST_RUN;
          wfi     <= 1'b0;
          led_bus <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: directed scenarios plus random traffic, checked every
// cycle against a period-phase reference model.
module tb_led_pwm_ctrl;
  localparam int P    = 16;
  localparam int W    = 4;
  localparam int MAXD = (1 << W) - 1;
  localparam int PER  = P * (1 << W);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, core_wfi;
  logic [3:0] addr;
  logic [7:0] wdata, rd_data, led_bus;
  logic       wfi;

  led_pwm_ctrl #(.PRESCALE(P), .DUTY_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rd_data  (rd_data),
    .core_wfi (core_wfi),
    .led_bus  (led_bus),
    .wfi      (wfi)
  );

  always #5 clk = ~clk;

  // model: m_t is the cycle position inside the current PWM period
  int         m_t;
  bit         m_frz, m_drn, m_pend, m_wfi;
  int         m_dsh[8], m_dact[8];
  logic [7:0] m_ensh, m_enact, m_led, m_rd;
  int         n_pass, n_chk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_t = 0; m_frz = 0; m_drn = 0; m_pend = 0; m_wfi = 0;
    m_ensh = 0; m_enact = 0; m_led = 0; m_rd = 0;
    for (int i = 0; i < 8; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
  endtask

  task automatic model_step();
    bit         tick, pend_end, commit, wok;
    int         pwm;
    logic [7:0] led_n;
    pwm      = m_t / P;
    tick     = !m_frz && (m_t % P == P - 1);
    pend_end = tick && (m_t == PER - 1);
    for (int i = 0; i < 8; i++)
      led_n[i] = m_enact[i] && ((pwm < m_dact[i]) || (m_dact[i] == MAXD));
    if (rd_en) begin
      if (addr < 8)       m_rd = 8'(m_dsh[addr]);
      else if (addr == 8) m_rd = m_ensh;
      else if (addr == 9) m_rd = {6'b0, m_pend, m_frz};
      else                m_rd = 8'h00;
    end
    commit = pend_end || (m_frz && !core_wfi);
    wok    = wr_en && (addr <= 8);
    if (commit) begin
      for (int i = 0; i < 8; i++) m_dact[i] = m_dsh[i];
      m_enact = m_ensh;
    end
    if (wok) begin
      if (addr == 8) m_ensh = wdata;
      else           m_dsh[addr] = int'(wdata) % (MAXD + 1);
      m_pend = 1;
    end else if (commit) m_pend = 0;
    if (m_frz) begin
      led_n = 0;
      if (!core_wfi) begin m_frz = 0; m_wfi = 0; end
    end else if (m_drn && core_wfi && pend_end) begin
      m_frz = 1; m_drn = 0; m_wfi = 1; led_n = 0; m_t = 0;
    end else begin
      m_drn = core_wfi;
      m_t   = (m_t + 1) % PER;
    end
    m_led = led_n;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("led_bus", led_bus, m_led);
    chk("wfi", wfi, m_wfi);
    chk("rd_data", rd_data, m_rd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1; addr = a; wdata = d;
    cyc();
    wr_en = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1; addr = a;
    cyc();
    rd_en = 0;
  endtask

  task automatic wait_t(input int target);
    for (int i = 0; i < PER + 2 && m_t != target; i++) cyc();
  endtask

  task automatic count_bit(input int b, output int hi);
    hi = 0;
    for (int i = 0; i < PER; i++) begin cyc(); hi += int'(led_bus[b]); end
  endtask

  initial begin
    int hi, hi2, burst, k;
    n_pass = 0; n_chk = 0;
    rst_n = 0; wr_en = 0; rd_en = 0; core_wfi = 0; addr = 0; wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led", led_bus, 8'h00);
    chk("reset_wfi", wfi, 1'b0);
    chk("reset_rd", rd_data, 8'h00);
    rst_n = 1;

    // duty 4 on bit 0: 64 of every 256 cycles high
    wr(4'd0, 8'd4); wr(4'd8, 8'h01);
    run(300);
    count_bit(0, hi);
    chk("duty4_hi", hi, 64);

    // duty 0 and all-ones
    wr(4'd1, 8'd0); wr(4'd2, 8'd15); wr(4'd8, 8'h06);
    run(300);
    count_bit(1, hi);
    count_bit(2, hi2);
    chk("duty0_hi", hi, 0);
    chk("dutymax_hi", hi2, PER);

    // mid-period duty change
    wr(4'd8, 8'h01);
    run(300);
    wait_t(2 * P);
    wr(4'd0, 8'd12);
    rd(4'd9);
    chk("status_pend", rd_data, 8'h02);
    wait_t(0);
    run(5);
    count_bit(0, hi);
    chk("duty12_hi", hi, 192);

    // freeze at a clean period end, then wake
    wait_t(5 * P);
    core_wfi = 1;
    for (k = 0; k < PER + 4 && !wfi; k++) cyc();
    chk("freeze_wfi", wfi, 1'b1);
    run(20);
    chk("frozen_led", led_bus, 8'h00);
    rd(4'd9);
    chk("status_frz", rd_data[0], 1'b1);
    core_wfi = 0;
    cyc();
    chk("wake_wfi", wfi, 1'b0);
    run(300);

    // short WFI pulse aborts the drain
    wait_t(100);
    core_wfi = 1;
    run(10);
    core_wfi = 0;
    chk("abort_wfi", wfi, 1'b0);
    run(300);

    wr(4'd3, 8'hAB);
    rd(4'd3);
    chk("rdback", rd_data, 8'h0B);
    wr(4'd12, 8'h55);
    rd(4'd12);
    chk("rd_unmapped", rd_data, 8'h00);

    // random traffic
    burst = 0;
    for (int i = 0; i < 5000; i++) begin
      if (burst == 0) begin
        core_wfi = ($urandom_range(0, 2) == 0);
        burst    = core_wfi ? $urandom_range(3, 600) : $urandom_range(20, 400);
      end
      burst--;
      wr_en = ($urandom_range(0, 7) == 0);
      rd_en = ($urandom_range(0, 3) == 0);
      addr  = 4'($urandom_range(0, 15));
      wdata = 8'($urandom);
      cyc();
    end
    wr_en = 0; rd_en = 0; core_wfi = 0;
    run(3);

    // async reset while frozen
    wr(4'd8, 8'hFF);
    core_wfi = 1;
    for (k = 0; k < PER + 4 && !wfi; k++) cyc();
    chk("freeze2_wfi", wfi, 1'b1);
    rd(4'd8);
    chk("rd_en_reg", rd_data, 8'hFF);
    #2 rst_n = 0;
    #1;
    chk("arst_wfi", wfi, 1'b0);
    chk("arst_led", led_bus, 8'h00);
    chk("arst_rd", rd_data, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
